irq_pending_arb: RTL
====================

// Module: irq_pending_arb
// PURPOSE
//   Upstream stage of the ISR-entrance lookup. Detects rising edges on the external
//   interrupt lines, latches them as pending, and arbitrates by fixed priority against
//   the in-service set to support nesting.
//   Presents one registered interrupt number plus a request to the core. Tracks
//   entry/return so that only strictly higher-priority lines preempt a running ISR.
// PARAMETERS
//   N_IRQ     3  number of interrupt lines; index N_IRQ-1 is highest priority
//   NBIT_IRQ  2  width of inum; must equal `NBIT_IRQ and satisfy 2**NBIT_IRQ >= N_IRQ
// PORTS
//   clk       in   1         system clock, all state updates on posedge
//   rst_n     in   1         synchronous reset, active low
//   irq_src   in   N_IRQ     raw interrupt lines, already synchronous to clk
//   irq_mask  in   N_IRQ     1 = line may request; masked lines still latch pending
//   irq_en    in   1         global interrupt enable
//   take      in   1         core jumps to ISR of inum this cycle (instruction boundary)
//   eret      in   1         core returns from the current (highest in-service) ISR
//   irq_req   out  1         request to core; inum valid while high
//   inum      out  NBIT_IRQ  interrupt number for the ISR-entrance lookup
//   pend      out  N_IRQ     pending bits
//   insvc     out  N_IRQ     in-service bits (nesting stack as bitmask)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): pend=0, insvc=0, irq_req=0, inum=0, prev=all-ones.
//     prev all-ones: a line high through reset raises nothing until it drops and rises.
//   Edge detect: prev<=irq_src each cycle; edge[i]=irq_src[i]&~prev[i].
//   Per-cycle update order within one edge (next-state, all registered):
//     1. eret: clear highest set bit of insvc; ignored if insvc==0.
//     2. take (honoured only if irq_req==1): pend[inum]<=0, insvc[inum]<=1.
//     3. edge[i]: pend[i]<=1; wins over step 2 clear (new edge in take cycle re-pends).
//   Arbitration on next-state values: cand=pend_n&irq_mask; top=highest set bit of cand;
//     cur=highest set bit of insvc_n (or -1 if none).
//     irq_req<=irq_en & (cand!=0) & (top>cur); inum<=top if request, else 0.
//   Consequences:
//     - Latency: edge sampled at posedge k -> pend and irq_req high after posedge k.
//     - After take at posedge k, irq_req/inum already reflect the post-take state.
//       No stale request, so a second take cannot retrigger the same line.
//     - Equal/lower-priority pending lines wait until eret lowers cur below them.
//     - take while irq_req==0: no effect. eret+take same cycle: step 1 then step 2.
//     - irq_en or mask dropping: irq_req deasserts after the next posedge; pend kept.
//     - Repeated edges on an already-pending line coalesce (single pend bit).
//   Outputs pend and insvc are the registers themselves.
// TESTING
//   1. Reset with irq_src=3'b001 held high -> no pend; drop then raise src[0]
//      -> pend=001, irq_req=1, inum=0 one posedge after the rise.
//   2. Edges on src[0] and src[2] same cycle, mask=111, en=1 -> inum=2.
//      take -> insvc=100, pend=001, irq_req=0 (0<2).
//      eret -> insvc=000, irq_req=1, inum=0.
//   3. In-service 0, src[1] edge -> irq_req=1, inum=1 (nesting).
//      take -> insvc=011. First eret clears bit1 only -> insvc=001.
//   4. mask=110, src[0] edge -> pend=001, irq_req=0.
//      Set mask=111 -> irq_req=1 after next posedge with inum=0; en=0 -> irq_req=0.
//   5. take of line 1 in the same cycle as a new src[1] edge -> insvc[1]=1, pend[1]=1.
//      irq_req=0 until eret, then irq_req=1, inum=1.
//   6. rst_n=0 mid-ISR (insvc=101, pend=010) -> all cleared next posedge.
//      take and eret asserted while irq_req=0 -> no state change.

Source files
------------

// File: rtl/irq_pending_arb_if.sv
// Request/return bundle between the interrupt lines, the core and the pending arbiter.
// The master drives lines, mask, enable and take/eret. The slave returns the request and its state.
interface irq_pending_arb_if #(
    parameter int N_IRQ    = 3,
    parameter int NBIT_IRQ = 2
);
    logic [N_IRQ-1:0]    irq_src;
    logic [N_IRQ-1:0]    irq_mask;
    logic                irq_en;
    logic                take;
    logic                eret;
    logic                irq_req;
    logic [NBIT_IRQ-1:0] inum;
    logic [N_IRQ-1:0]    pend;
    logic [N_IRQ-1:0]    insvc;

    modport master (
        output irq_src, irq_mask, irq_en, take, eret,
        input  irq_req, inum, pend, insvc
    );

    modport slave (
        input  irq_src, irq_mask, irq_en, take, eret,
        output irq_req, inum, pend, insvc
    );
endinterface

// File: rtl/irq_pending_arb.sv
// Edge-latched pending interrupts with fixed-priority arbitration against the in-service set.
// Only a strictly higher-priority line preempts a running ISR.
module irq_pending_arb #(
    parameter int N_IRQ    = 3,
    parameter int NBIT_IRQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    irq_pending_arb_if.slave  bus
);

    logic [N_IRQ-1:0]    prev;
    logic [N_IRQ-1:0]    pend_r;
    logic [N_IRQ-1:0]    insvc_r;
    logic                irq_req_r;
    logic [NBIT_IRQ-1:0] inum_r;

    logic [N_IRQ-1:0]    edge_v;
    logic [N_IRQ-1:0]    pend_n;
    logic [N_IRQ-1:0]    insvc_n;
    logic [N_IRQ-1:0]    cand;
    logic [NBIT_IRQ-1:0] top;
    logic [NBIT_IRQ-1:0] cur;
    logic                take_ok;
    logic                req_n;

    function automatic logic [NBIT_IRQ-1:0] msb_idx(input logic [N_IRQ-1:0] v);
        msb_idx = '0;
        for (int i = 0; i < N_IRQ; i++)
            if (v[i]) msb_idx = NBIT_IRQ'(i);
    endfunction

    function automatic logic [N_IRQ-1:0] clr_msb(input logic [N_IRQ-1:0] v);
        logic done;
        clr_msb = v;
        done    = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i] && !done) begin
                clr_msb[i] = 1'b0;
                done       = 1'b1;
            end
        end
    endfunction

    // A take is only honoured against the request the core actually saw.
    assign take_ok = bus.take & irq_req_r;
    assign edge_v  = bus.irq_src & ~prev;

    always_comb begin
        insvc_n = insvc_r;
        pend_n  = pend_r;
        if (bus.eret)
            insvc_n = clr_msb(insvc_r);
        for (int i = 0; i < N_IRQ; i++) begin
            if (take_ok && (i == int'(inum_r))) begin
                insvc_n[i] = 1'b1;
                pend_n[i]  = 1'b0;
            end
        end
        // A fresh edge re-pends even the line being taken this cycle.
        pend_n = pend_n | edge_v;
    end

    assign cand  = pend_n & bus.irq_mask;
    assign top   = msb_idx(cand);
    assign cur   = msb_idx(insvc_n);
    assign req_n = bus.irq_en & (|cand) & (~(|insvc_n) | (top > cur));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev      <= '1;
            pend_r    <= '0;
            insvc_r   <= '0;
            irq_req_r <= 1'b0;
            inum_r    <= '0;
        end else begin
            prev      <= bus.irq_src;
            pend_r    <= pend_n;
            insvc_r   <= insvc_n;
            irq_req_r <= req_n;
            inum_r    <= req_n ? top : '0;
        end
    end

    assign bus.pend    = pend_r;
    assign bus.insvc   = insvc_r;
    assign bus.irq_req = irq_req_r;
    assign bus.inum    = inum_r;

endmodule
